uart_cmd_seq: RTL and testbench
===============================

// Module: uart_cmd_seq
// PURPOSE
//  Command sequencer on the DSO host link: consumes bytes from the UART receiver (rdy/clr_rdy handshake),
//  assembles CMD_BYTES-byte commands (opcode first, MSB-first), holds each until the command decoder
//  acknowledges it, and drops partial frames after an inter-byte timeout. Sits between uart_rx and cmd_cfg.
// PARAMETERS
//  CMD_BYTES    3      bytes per command frame (2..4); cmd width = 8*CMD_BYTES
//  TIMEOUT_CYC  4096   clk cycles allowed between bytes of one frame before it is discarded (>=16)
// PORTS
//  clk          in   1              system clock
//  rst_n        in   1              reset, asynchronous, active-low
//  rx_rdy       in   1              byte available from uart_rx
//  rx_data      in   8              received byte, valid while rx_rdy=1
//  clr_rx_rdy   out  1              one-cycle pulse: byte consumed (to uart_rx clr_rdy)
//  cmd          out  8*CMD_BYTES    assembled command, opcode in [8*CMD_BYTES-1 -: 8]
//  cmd_rdy      out  1              cmd valid; held until clr_cmd_rdy
//  clr_cmd_rdy  in   1              decoder acknowledge
//  frame_err    out  1              one-cycle pulse: partial frame dropped on timeout
//  busy         out  1              high whenever 1..CMD_BYTES-1 bytes are held
// BEHAVIOUR
//  Reset: state=IDLE, cmd=0, cmd_rdy=0, clr_rx_rdy=0, frame_err=0, busy=0, byte_cnt=0, tmo=0. All outputs registered.
//  States: IDLE, COLLECT, CONSUME, HOLD.
//   IDLE/COLLECT: rx_rdy=1 sampled at edge k -> shift {cmd[8*CMD_BYTES-9:0], rx_data} into cmd, byte_cnt+1,
//    go CONSUME; clr_rx_rdy=1 during cycle k+1 only.
//   CONSUME (1 cycle, rx_rdy ignored - uart_rx drops rdy at end of this cycle): if byte_cnt==CMD_BYTES
//    -> HOLD, cmd_rdy=1 from cycle k+2; else -> COLLECT.
//   HOLD: cmd/cmd_rdy stable; rx_rdy NOT consumed (byte left pending in uart_rx, taken as first byte of next
//    frame). clr_cmd_rdy=1 -> cmd_rdy=0 next cycle, byte_cnt=0, -> IDLE. cmd register keeps its value.
//  clr_cmd_rdy outside HOLD: ignored.
//  Timeout: tmo counts each cycle in COLLECT, cleared on every capture and in IDLE/HOLD. At tmo==TIMEOUT_CYC-1
//   in COLLECT: byte_cnt=0, frame_err pulse next cycle, -> IDLE; cmd not cleared, cmd_rdy stays 0.
//  Simultaneous rx_rdy and timeout in COLLECT: byte capture wins, tmo cleared, no frame_err.
//  busy = (byte_cnt!=0) & ~cmd_rdy.
//  byte_cnt width clog2(CMD_BYTES+1); never exceeds CMD_BYTES. tmo width clog2(TIMEOUT_CYC); never wraps.
//  Reset mid-frame or in HOLD: all state/outputs return to reset values immediately (async); pending byte lost
//   only if uart_rx also resets.
// STRUCTURE
//  Package dso_pkg: cmd_seq_state_t enum {IDLE,COLLECT,CONSUME,HOLD}; CMD_BYTES default; opcode localparams
//   shared with cmd_cfg.
//  One sub-module: cmd_tmo_cnt (clear, enable, terminal-count pulse, param TIMEOUT_CYC). FSM, shift register
//   and byte counter stay in this module.
// TESTING
//  1 Bytes 0x05,0xA3,0x7C spaced 500 cyc -> three clr_rx_rdy pulses, cmd_rdy=1 with cmd=24'h05A37C two cycles
//    after third rx_rdy; clr_cmd_rdy -> cmd_rdy=0 next cycle, busy=0.
//  2 Bytes 0x11,0x22 then silence TIMEOUT_CYC cyc -> frame_err single pulse, busy=0; then 0x33,0x44,0x55 -> cmd=24'h334455.
//  3 rx_rdy held high during HOLD for 100 cyc -> no clr_rx_rdy; after clr_cmd_rdy, byte consumed within 2 cycles as
//    first byte (busy=1, byte_cnt=1).
//  4 rx_rdy asserted on exact timeout cycle -> byte captured, no frame_err, frame continues.
//  5 rst_n low after 2 bytes -> all outputs 0 immediately; subsequent 3-byte frame assembles correctly.
//  6 clr_cmd_rdy pulsed in IDLE and COLLECT -> no effect on byte_cnt, cmd, or state; clr_rx_rdy never 2 cycles wide.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared types and constants for the DSO host-link command path.
package dso_pkg;

  // Command sequencer FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CONSUME = 2'd2,
    HOLD    = 2'd3
  } cmd_seq_state_t;

  // Default frame length in bytes (opcode + operands)
  localparam int CMD_BYTES_DEFAULT = 3;

  // Opcodes understood by cmd_cfg (first byte of every frame)
  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_SET_CH    = 8'h01;
  localparam logic [7:0] OP_SET_VDIV  = 8'h02;
  localparam logic [7:0] OP_SET_TRIG  = 8'h03;
  localparam logic [7:0] OP_SET_LEVEL = 8'h04;
  localparam logic [7:0] OP_SET_TBASE = 8'h05;
  localparam logic [7:0] OP_ARM       = 8'h10;
  localparam logic [7:0] OP_STOP      = 8'h11;

endpackage

// File: rtl/cmd_tmo_cnt.sv
// Inter-byte timeout counter: counts while enabled, saturates at the
// terminal value and flags it combinationally for the owning FSM.
module cmd_tmo_cnt #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo;

  // Count enabled cycles; clear has priority and the count never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if (clr) begin
      tmo <= '0;
    end else if (en && (tmo != LAST)) begin
      tmo <= tmo + 1'b1;
    end
  end

  assign tc = en && (tmo == LAST);

endmodule

// File: rtl/uart_cmd_seq.sv
// Assembles multi-byte host commands from uart_rx, holds each frame until
// the decoder acknowledges it, and drops stale partial frames on timeout.
module uart_cmd_seq
  import dso_pkg::*;
#(
  parameter int CMD_BYTES   = CMD_BYTES_DEFAULT,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int CW    = 8 * CMD_BYTES;
  localparam int CNT_W = $clog2(CMD_BYTES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CMD_BYTES);

  cmd_seq_state_t   state;
  logic [CNT_W-1:0] byte_cnt;
  logic             accepting;
  logic             tmo_clr;
  logic             tmo_en;
  logic             tmo_tc;

  // A byte is taken only while waiting for one; a capture restarts the gap timer
  assign accepting = (state == IDLE) || (state == COLLECT);
  assign tmo_en    = (state == COLLECT);
  assign tmo_clr   = (state != COLLECT) || rx_rdy;

  cmd_tmo_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  // Frame FSM with shift register, byte counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      clr_rx_rdy <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      clr_rx_rdy <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (accepting && rx_rdy) begin
            // Capture beats a coincident timeout
            cmd        <= {cmd[CW-9:0], rx_data};
            byte_cnt   <= byte_cnt + 1'b1;
            clr_rx_rdy <= 1'b1;
            busy       <= 1'b1;
            state      <= CONSUME;
          end else if ((state == COLLECT) && tmo_tc) begin
            // Stale partial frame: forget it, leave cmd contents alone
            byte_cnt   <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b1;
            state      <= IDLE;
          end
        end
        CONSUME: begin
          // uart_rx still shows rdy this cycle, so it is not looked at here
          if (byte_cnt == FULL) begin
            cmd_rdy <= 1'b1;
            busy    <= 1'b0;
            state   <= HOLD;
          end else begin
            state   <= COLLECT;
          end
        end
        HOLD: begin
          // Pending bytes stay in uart_rx until the decoder frees us
          if (clr_cmd_rdy) begin
            cmd_rdy  <= 1'b0;
            byte_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq: frame assembly, hold/ack, timeout drop,
// capture-vs-timeout race, async reset and stray acknowledges.
module tb_uart_cmd_seq;
  import dso_pkg::*;

  localparam int CMD_BYTES   = 3;
  localparam int TIMEOUT_CYC = 4096;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int clr_run  = 0;
  int clr_max  = 0;

  uart_cmd_seq #(
    .CMD_BYTES   (CMD_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track the widest clr_rx_rdy pulse seen
  always @(negedge clk) begin
    if (clr_rx_rdy) clr_run = clr_run + 1;
    else            clr_run = 0;
    if (clr_run > clr_max) clr_max = clr_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte as uart_rx would and check the consume handshake
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
    check("clr_rx_rdy_hi", 32'(clr_rx_rdy), 32'd1);
    rx_rdy = 1'b0;
    @(negedge clk);
    check("clr_rx_rdy_lo", 32'(clr_rx_rdy), 32'd0);
  endtask

  task automatic ack();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("ack_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("ack_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int m;
    int w;
    int seen;
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    #1;
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_clr_rx", 32'(clr_rx_rdy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 1: spaced bytes form one command, then acknowledge
    send_byte(8'h05);
    tick(500);
    check("t1_busy1", 32'(busy), 32'd1);
    send_byte(8'hA3);
    tick(500);
    check("t1_cnt2", 32'(dut.byte_cnt), 32'd2);
    send_byte(8'h7C);
    check("t1_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t1_cmd", 32'(cmd), 32'h05A37C);
    check("t1_busy_hold", 32'(busy), 32'd0);
    tick(3);
    check("t1_cmd_stable", 32'(cmd), 32'h05A37C);
    ack();
    check("t1_cmd_kept", 32'(cmd), 32'h05A37C);

    // 2: partial frame times out, next frame is clean
    send_byte(8'h11);
    send_byte(8'h22);
    check("t2_busy", 32'(busy), 32'd1);
    m = 0;
    while (!frame_err && m < TIMEOUT_CYC + 500) begin
      @(negedge clk);
      m++;
    end
    check("t2_tmo_cycles", 32'(m), 32'(TIMEOUT_CYC));
    check("t2_ferr", 32'(frame_err), 32'd1);
    check("t2_busy0", 32'(busy), 32'd0);
    check("t2_cmd_rdy0", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    check("t2_ferr_pulse", 32'(frame_err), 32'd0);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    check("t2_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t2_cmd", 32'(cmd), 32'h334455);
    ack();

    // 3: byte pending during HOLD is left alone, then taken as first byte
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("t3_cmd", 32'(cmd), 32'hAABBCC);
    rx_rdy  = 1'b1;
    rx_data = 8'hDD;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) seen++;
    end
    check("t3_no_consume", 32'(seen), 32'd0);
    check("t3_hold_cmd", 32'(cmd), 32'hAABBCC);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("t3_ack", 32'(cmd_rdy), 32'd0);
    w = 0;
    while (!clr_rx_rdy && w < 3) begin
      @(negedge clk);
      w++;
    end
    check("t3_consume_lat_ok", 32'(w <= 2), 32'd1);
    check("t3_clr_rx", 32'(clr_rx_rdy), 32'd1);
    rx_rdy = 1'b0;
    @(negedge clk);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_cnt", 32'(dut.byte_cnt), 32'd1);
    check("t3_low_byte", 32'(cmd[7:0]), 32'hDD);
    send_byte(8'hEE);
    send_byte(8'hFF);
    check("t3_cmd2", 32'(cmd), 32'hDDEEFF);
    ack();

    // 4: byte arriving on the terminal timeout cycle wins
    send_byte(8'h01);
    tick(TIMEOUT_CYC - 1);
    rx_rdy  = 1'b1;
    rx_data = 8'h02;
    @(negedge clk);
    check("t4_clr_rx", 32'(clr_rx_rdy), 32'd1);
    check("t4_no_ferr", 32'(frame_err), 32'd0);
    rx_rdy = 1'b0;
    @(negedge clk);
    check("t4_no_ferr2", 32'(frame_err), 32'd0);
    check("t4_cnt", 32'(dut.byte_cnt), 32'd2);
    check("t4_busy", 32'(busy), 32'd1);
    send_byte(8'h03);
    check("t4_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t4_cmd", 32'(cmd), 32'h010203);
    ack();

    // 5: async reset mid-frame
    send_byte(8'h10);
    send_byte(8'h20);
    rst_n = 1'b0;
    #1;
    check("t5_cmd", 32'(cmd), 32'h0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("t5_cnt", 32'(dut.byte_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h50);
    check("t5_cmd2", 32'(cmd), 32'h304050);
    check("t5_cmd_rdy2", 32'(cmd_rdy), 32'd1);
    ack();

    // 6: stray acknowledges outside HOLD are ignored
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("t6_idle_cnt", 32'(dut.byte_cnt), 32'd0);
    check("t6_idle_cmd", 32'(cmd), 32'h304050);
    check("t6_idle_state", 32'(dut.state), 32'(IDLE));
    send_byte(8'h61);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("t6_col_cnt", 32'(dut.byte_cnt), 32'd1);
    check("t6_col_cmd", 32'(cmd), 32'h405061);
    check("t6_col_state", 32'(dut.state), 32'(COLLECT));
    check("t6_col_busy", 32'(busy), 32'd1);
    send_byte(8'h62);
    send_byte(8'h63);
    check("t6_cmd", 32'(cmd), 32'h616263);
    ack();
    check("t6_clr_width", 32'(clr_max), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
